mod_unit_arbiter: RTL and testbench

- Shares one multi-cycle modulo unit (control unit plus datapath, start/done handshake) between NREQ requesters.
- Round-robin arbitration. Latches the winner's operands and drives the unit's start level until done.
- Returns the result with a one-cycle ack to the winner, then waits for the unit to drop done before re-arbitrating.
- Sits between the ALU front-end ports and the shared modulo unit.

---
 rtl/mod_unit_arbiter.sv | 140 ++++++++++++++
 tb/tb_mod_unit_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mod_unit_arbiter.sv
// Round-robin arbiter sharing one multi-cycle modulo unit (start/done level handshake) among NREQ requesters.
// Define MOD_ARB_TIMEOUT_EN to bound the WAIT state by TIMEOUT cycles and add the err pulse output.
module mod_unit_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_bus,
    input  logic [NREQ*W-1:0] b_bus,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   ack,
    output logic [W-1:0]      result,
    output logic              busy,
    output logic              unit_start,
    output logic [W-1:0]      unit_a,
    output logic [W-1:0]      unit_b,
    input  logic              unit_done,
    input  logic [W-1:0]      unit_result
`ifdef MOD_ARB_TIMEOUT_EN
    ,
    output logic              err
`endif
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] ptr, gidx, pick_idx, ptr_after;
    logic [PW:0]   scan;
    logic          pick_vld;
    logic          timeout_hit;

`ifdef MOD_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;

    // wait_cnt holds the number of WAIT cycles already spent, so the abort fires on the TIMEOUT-th one.
    assign timeout_hit = (state == WAIT) && !unit_done && (wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            err      <= timeout_hit;
            wait_cnt <= (state == WAIT) ? wait_cnt + CW'(1) : '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign unit_start = (state == ISSUE) || (state == WAIT);
    assign busy       = (state != IDLE);
    assign ptr_after  = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);

    // Scan ptr, ptr+1, ... modulo NREQ; the first asserted request wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan     = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, ptr} + (PW + 1)'(k);
            if (scan >= (PW + 1)'(NREQ))
                scan = scan - (PW + 1)'(NREQ);
            if (!pick_vld && req[scan[PW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = scan[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT: begin
                if (unit_done)
                    state_nxt = RESP;
                else if (timeout_hit)
                    state_nxt = DRAIN;
            end
            RESP:    state_nxt = DRAIN;
            DRAIN:   if (!unit_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ack is a single-cycle pulse: cleared every cycle unless a completion sets it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr    <= '0;
            gidx   <= '0;
            gnt    <= '0;
            ack    <= '0;
            result <= '0;
            unit_a <= '0;
            unit_b <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        gidx          <= pick_idx;
                        gnt           <= '0;
                        gnt[pick_idx] <= 1'b1;
                        unit_a        <= a_bus[pick_idx*W +: W];
                        unit_b        <= b_bus[pick_idx*W +: W];
                    end
                end
                WAIT: begin
                    if (unit_done) begin
                        result <= unit_result;
                        ack    <= gnt;
                    end else if (timeout_hit) begin
                        result <= '0;
                        ack    <= gnt;
                        ptr    <= ptr_after;
                    end
                end
                RESP:    ptr <= ptr_after;
                DRAIN:   if (!unit_done) gnt <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_unit_arbiter.sv
// Self-checking bench for mod_unit_arbiter: behavioural modulo unit plus a transaction-level
// round-robin reference model; timeout scenario included when MOD_ARB_TIMEOUT_EN is defined.
module tb_mod_unit_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_bus, b_bus;
    logic [NREQ-1:0]   gnt, ack;
    logic [W-1:0]      result, unit_a, unit_b, unit_result;
    logic              busy, unit_start, unit_done;
`ifdef MOD_ARB_TIMEOUT_EN
    logic              err;
`endif

    int checks = 0;
    int errors = 0;
    int mptr   = 0;
    int u_lat  = 3;
    int u_drop = 0;
    int u_cnt, u_hold;

    mod_unit_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .req(req), .a_bus(a_bus), .b_bus(b_bus),
        .gnt(gnt), .ack(ack), .result(result), .busy(busy), .unit_start(unit_start),
        .unit_a(unit_a), .unit_b(unit_b), .unit_done(unit_done), .unit_result(unit_result)
`ifdef MOD_ARB_TIMEOUT_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural modulo unit: done rises u_lat+1 start cycles after start, held while start is high,
    // dropped u_drop cycles after start goes low.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            u_cnt <= 0; u_hold <= 0; unit_done <= 1'b0; unit_result <= '0;
        end else if (unit_start) begin
            u_hold <= 0;
            if (u_cnt >= u_lat) begin
                unit_done   <= 1'b1;
                unit_result <= unit_a % unit_b;
            end else begin
                u_cnt <= u_cnt + 1;
            end
        end else begin
            u_cnt <= 0;
            if (unit_done) begin
                if (u_hold >= u_drop) unit_done <= 1'b0;
                else u_hold <= u_hold + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return 0;
    endfunction

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        a_bus[i*W +: W] = a;
        b_bus[i*W +: W] = b;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // One full transaction, started with the arbiter idle and req/operands stable.
    task automatic do_txn(input string tag, input bit drop, input bit scramble);
        int w, n;
        logic [W-1:0] ea, eb;
        w  = model_pick(req, mptr);
        ea = a_bus[w*W +: W];
        eb = b_bus[w*W +: W];
        n = 0;
        while (gnt === '0 && n < 50) begin tick(); n++; end
        check({tag, ".gnt"}, gnt, 64'(1) << w);
        check({tag, ".unit_a"}, unit_a, ea);
        check({tag, ".unit_b"}, unit_b, eb);
        check({tag, ".start"}, unit_start, 1);
        if (scramble)
            for (int i = 0; i < NREQ; i++) set_op(i, $urandom, $urandom_range(1, 1000));
        n = 0;
        while (ack === '0 && n < 100) begin tick(); n++; end
        check({tag, ".ack"}, ack, 64'(1) << w);
        check({tag, ".result"}, result, ea % eb);
        check({tag, ".start_low"}, unit_start, 0);
        check({tag, ".a_hold"}, unit_a, ea);
`ifdef MOD_ARB_TIMEOUT_EN
        check({tag, ".err"}, err, 0);
`endif
        tick();
        check({tag, ".ack_pulse"}, ack, 0);
        check({tag, ".gnt_drain"}, gnt, 64'(1) << w);
        if (drop) req[w] = 1'b0;
        mptr = (w + 1) % NREQ;
        n = 0;
        while (busy !== 1'b0 && n < 50) begin tick(); n++; end
        check({tag, ".gnt_clr"}, gnt, 0);
        check({tag, ".result_hold"}, result, ea % eb);
    endtask

    initial begin
        int n;
        reset = 1'b0; req = '0; a_bus = '0; b_bus = '0;
        repeat (3) tick();
        check("rst.gnt", gnt, 0);
        check("rst.ack", ack, 0);
        check("rst.result", result, 0);
        check("rst.unit_ab", {unit_a, unit_b}, 0);
        check("rst.start", unit_start, 0);
        check("rst.busy", busy, 0);
`ifdef MOD_ARB_TIMEOUT_EN
        check("rst.err", err, 0);
`endif
        reset = 1'b1;
        tick();

        // Single request, unit answers after 6 cycles
        u_lat = 5; u_drop = 2;
        set_op(0, 17, 5);
        req = 4'b0001;
        do_txn("single", 1, 0);

        // Fairness: ptr is now 1, so req2 beats req0
        u_drop = 0;
        set_op(0, 23, 6); set_op(2, 40, 9);
        req = 4'b0101;
        check("fair.first", model_pick(req, mptr), 2);
        do_txn("fair2", 1, 0);
        check("fair.ptr", mptr, 3);
        do_txn("fair0", 1, 0);

        // Operand changes after the latch must not reach the unit
        set_op(0, 17, 5);
        req = 4'b0001;
        do_txn("hold", 1, 1);

        // Reset in the middle of WAIT
        u_lat = 20;
        set_op(0, 17, 5); set_op(1, 50, 8);
        req = 4'b0001;
        n = 0;
        while (gnt === '0 && n < 50) begin tick(); n++; end
        tick(); tick();
        check("rstmid.in_wait", unit_start, 1);
        #2 reset = 1'b0;
        #1;
        check("rstmid.start", unit_start, 0);
        check("rstmid.gnt", gnt, 0);
        check("rstmid.busy", busy, 0);
        req = 4'b0010;
        mptr = 0;
        tick();
        reset = 1'b1;
        u_lat = 2;
        do_txn("rstmid.after", 1, 0);

        // Round-robin with every request held, from ptr=0
        reset = 1'b0; tick(); reset = 1'b1; mptr = 0; tick();
        for (int i = 0; i < NREQ; i++) set_op(i, 100 + i, 7);
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            check("rr.order", model_pick(req, mptr), t % NREQ);
            do_txn("rr", 0, 0);
        end
        req = '0;
        tick();

        // Randomized traffic
        for (int t = 0; t < 25; t++) begin
            u_lat  = $urandom_range(0, 8);
            u_drop = $urandom_range(0, 3);
            for (int i = 0; i < NREQ; i++) set_op(i, $urandom, $urandom_range(1, 5000));
            req = NREQ'($urandom_range(1, 15));
            do_txn("rand", $urandom_range(0, 1), $urandom_range(0, 1));
        end
        req = '0;
        tick();

`ifdef MOD_ARB_TIMEOUT_EN
        // Unit never completes: abort 15 cycles after WAIT entry
        u_lat = 1000;
        set_op(0, 17, 5);
        req = 4'b0001;
        n = 0;
        while (gnt === '0 && n < 50) begin tick(); n++; end
        check("to.gnt", gnt, 4'b0001);
        n = 0;
        while (ack === '0 && n < 100) begin tick(); n++; end
        req = '0;
        check("to.delay", n, 16);
        check("to.err", err, 1);
        check("to.ack", ack, 4'b0001);
        check("to.result", result, 0);
        tick();
        check("to.err_pulse", err, 0);
        check("to.ack_pulse", ack, 0);
        tick();
        check("to.idle", busy, 0);
        check("to.gnt_clr", gnt, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
